// File: rtl/output_decoder.sv
// Sequential argmax decoder: one class compared per cycle, result held on a valid/ready handshake.
// Optional reject of non-positive winners is enabled by defining OUTPUT_DECODER_REJECT_EN.
module output_decoder #(
    parameter int FP_WIDTH    = 8,
    parameter int FP_FRAC     = 5,
    parameter int NUM_CLASSES = 3,
    parameter int MARGIN      = 8,
    parameter int IDX_WIDTH   = $clog2(NUM_CLASSES + 1),
    parameter int DROP_WIDTH  = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_CLASSES*FP_WIDTH-1:0] VALUES_IN,
    input  logic                            VALID_IN,
    input  logic                            OVERFLOW_IN,
    output logic [IDX_WIDTH-1:0]            CLASS_OUT,
    output logic [FP_WIDTH-1:0]             CONFIDENCE_OUT,
    output logic                            AMBIGUOUS_OUT,
    output logic                            OVERFLOW_OUT,
    output logic                            VALID_OUT,
    input  logic                            READY_IN,
    output logic                            BUSY,
    output logic [DROP_WIDTH-1:0]           DROP_COUNT
);

    localparam int K_WIDTH = $clog2(NUM_CLASSES);
    localparam logic [K_WIDTH-1:0] LAST_K = K_WIDTH'(NUM_CLASSES - 1);
    localparam logic signed [FP_WIDTH-1:0] MOST_NEG = {1'b1, {(FP_WIDTH-1){1'b0}}};
    localparam logic [FP_WIDTH-1:0] CONF_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam logic [FP_WIDTH-1:0] MARGIN_LSB = FP_WIDTH'(MARGIN);
    localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    if (NUM_CLASSES < 2 || FP_FRAC >= FP_WIDTH) begin : g_paramCheck
        $error("output_decoder: needs NUM_CLASSES >= 2 and FP_FRAC < FP_WIDTH");
    end

    logic [1:0]                  r_state;
    logic signed [FP_WIDTH-1:0]  r_vals [NUM_CLASSES];
    logic                        r_ovfCapt;
    logic signed [FP_WIDTH-1:0]  r_best;
    logic signed [FP_WIDTH-1:0]  r_second;
    logic [K_WIDTH-1:0]          r_bestIdx;
    logic [K_WIDTH-1:0]          r_k;
    logic [IDX_WIDTH-1:0]        r_classOut;
    logic [FP_WIDTH-1:0]         r_confOut;
    logic                        r_ambOut;
    logic                        r_ovfOut;
    logic                        r_validOut;
    logic [DROP_WIDTH-1:0]       r_dropCount;

    logic signed [FP_WIDTH-1:0]  w_cur;
    logic signed [FP_WIDTH-1:0]  w_nextBest;
    logic signed [FP_WIDTH-1:0]  w_nextSecond;
    logic [K_WIDTH-1:0]          w_nextIdx;
    logic signed [FP_WIDTH:0]    w_diff;
    logic [FP_WIDTH-1:0]         w_conf;
    logic                        w_reject;
    logic [IDX_WIDTH-1:0]        w_class;
    logic                        w_amb;

    assign w_cur = r_vals[r_k];

    // A tie with the current best is not a win, so the lower index keeps it and the tie becomes runner-up.
    always_comb begin
        w_nextBest   = r_best;
        w_nextSecond = r_second;
        w_nextIdx    = r_bestIdx;
        if (w_cur > r_best) begin
            w_nextSecond = r_best;
            w_nextBest   = w_cur;
            w_nextIdx    = r_k;
        end else if (w_cur > r_second) begin
            w_nextSecond = w_cur;
        end
    end

    assign w_diff = {w_nextBest[FP_WIDTH-1], w_nextBest} - {w_nextSecond[FP_WIDTH-1], w_nextSecond};
    assign w_conf = (w_diff[FP_WIDTH] | w_diff[FP_WIDTH-1]) ? CONF_MAX : w_diff[FP_WIDTH-1:0];

`ifdef OUTPUT_DECODER_REJECT_EN
    assign w_reject = w_nextBest[FP_WIDTH-1] || (w_nextBest == '0);
`else
    assign w_reject = 1'b0;
`endif

    assign w_class = w_reject ? IDX_WIDTH'(NUM_CLASSES) : IDX_WIDTH'(w_nextIdx);
    assign w_amb   = w_reject || (w_conf < MARGIN_LSB);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_vals[i] <= '0;
            end
            r_ovfCapt  <= 1'b0;
            r_best     <= '0;
            r_second   <= '0;
            r_bestIdx  <= '0;
            r_k        <= '0;
            r_classOut <= '0;
            r_confOut  <= '0;
            r_ambOut   <= 1'b0;
            r_ovfOut   <= 1'b0;
            r_validOut <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (VALID_IN) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            r_vals[i] <= VALUES_IN[i*FP_WIDTH +: FP_WIDTH];
                        end
                        r_ovfCapt <= OVERFLOW_IN;
                        r_best    <= VALUES_IN[FP_WIDTH-1:0];
                        r_second  <= MOST_NEG;
                        r_bestIdx <= '0;
                        r_k       <= K_WIDTH'(1);
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_best    <= w_nextBest;
                    r_second  <= w_nextSecond;
                    r_bestIdx <= w_nextIdx;
                    r_k       <= r_k + K_WIDTH'(1);
                    // The last comparison feeds the outputs directly so no extra cycle is spent.
                    if (r_k == LAST_K) begin
                        r_classOut <= w_class;
                        r_confOut  <= w_conf;
                        r_ambOut   <= w_amb;
                        r_ovfOut   <= r_ovfCapt;
                        r_validOut <= 1'b1;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (READY_IN) begin
                        r_validOut <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Any pulse arriving outside IDLE is lost, including the cycle of the HOLD->IDLE handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dropCount <= '0;
        end else if (VALID_IN && (r_state != S_IDLE) && (r_dropCount != DROP_MAX)) begin
            r_dropCount <= r_dropCount + DROP_WIDTH'(1);
        end
    end

    assign CLASS_OUT      = r_classOut;
    assign CONFIDENCE_OUT = r_confOut;
    assign AMBIGUOUS_OUT  = r_ambOut;
    assign OVERFLOW_OUT   = r_ovfOut;
    assign VALID_OUT      = r_validOut;
    assign BUSY           = (r_state != S_IDLE);
    assign DROP_COUNT     = r_dropCount;

endmodule

// File: tb/tb_output_decoder.sv
// Scoreboard bench for output_decoder: a cycle-level reference model predicts results, a monitor compares them.
module tb_output_decoder;

    localparam int NC = 3;
    localparam int FW = 8;
    localparam int IW = $clog2(NC + 1);
    localparam int DW = 8;

    logic              CLK;
    logic              RST;
    logic [NC*FW-1:0]  VALUES_IN;
    logic              VALID_IN;
    logic              OVERFLOW_IN;
    logic [IW-1:0]     CLASS_OUT;
    logic [FW-1:0]     CONFIDENCE_OUT;
    logic              AMBIGUOUS_OUT;
    logic              OVERFLOW_OUT;
    logic              VALID_OUT;
    logic              READY_IN;
    logic              BUSY;
    logic [DW-1:0]     DROP_COUNT;

    typedef struct {
        int cls;
        int conf;
        int amb;
        int ovf;
        int due;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   drops = 0;
    int   epoch = 0;
    int   holdFrom = 0;
    bit   modelBusy = 1'b0;

    output_decoder dut (
        .CLK            (CLK),
        .RST            (RST),
        .VALUES_IN      (VALUES_IN),
        .VALID_IN       (VALID_IN),
        .OVERFLOW_IN    (OVERFLOW_IN),
        .CLASS_OUT      (CLASS_OUT),
        .CONFIDENCE_OUT (CONFIDENCE_OUT),
        .AMBIGUOUS_OUT  (AMBIGUOUS_OUT),
        .OVERFLOW_OUT   (OVERFLOW_OUT),
        .VALID_OUT      (VALID_OUT),
        .READY_IN       (READY_IN),
        .BUSY           (BUSY),
        .DROP_COUNT     (DROP_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Decision straight from the rules: first maximum wins, runner-up is the best of all other classes.
    function automatic exp_t predict(input logic [NC*FW-1:0] vals, input logic ovf);
        exp_t e;
        int   v[NC];
        int   best;
        int   idx;
        int   second;
        int   diff;
        for (int i = 0; i < NC; i++) begin
            v[i] = int'($signed(vals[i*FW +: FW]));
        end
        best = v[0];
        idx  = 0;
        for (int i = 1; i < NC; i++) begin
            if (v[i] > best) begin
                best = v[i];
                idx  = i;
            end
        end
        second = -(1 << (FW - 1));
        for (int i = 0; i < NC; i++) begin
            if (i != idx && v[i] > second) second = v[i];
        end
        diff   = best - second;
        e.conf = (diff > (1 << (FW - 1)) - 1) ? (1 << (FW - 1)) - 1 : diff;
        e.cls  = idx;
        e.amb  = (e.conf < 8) ? 1 : 0;
`ifdef OUTPUT_DECODER_REJECT_EN
        if (best <= 0) begin
            e.cls = NC;
            e.amb = 1;
        end
`endif
        e.ovf = int'(ovf);
        e.due = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [NC*FW-1:0] vals, input logic ovf);
        VALUES_IN   = vals;
        OVERFLOW_IN = ovf;
        VALID_IN    = 1'b1;
        tick();
        VALID_IN    = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 64 && modelBusy; i++) tick();
        if (modelBusy) checkOutput("idle_timeout", int'(BUSY), 0);
    endtask

    function automatic logic [NC*FW-1:0] randVals();
        logic [FW-1:0]    corners[6];
        logic [NC*FW-1:0] r;
        corners = '{8'h80, 8'h7F, 8'h00, 8'hE0, 8'h20, 8'h10};
        for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 2) == 0) r[i*FW +: FW] = corners[$urandom_range(0, 5)];
            else                            r[i*FW +: FW] = FW'($urandom);
        end
        return r;
    endfunction

    // Reference timing: accept only when idle, result due NC-1 edges later, freed by a handshake in hold.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            cyc++;
            if (RST) begin
                expQ.delete();
                modelBusy = 1'b0;
                drops     = 0;
                epoch++;
            end else if (modelBusy) begin
                if (VALID_IN && drops < (1 << DW) - 1) drops++;
                if (cyc >= holdFrom && READY_IN) modelBusy = 1'b0;
            end else if (VALID_IN) begin
                e         = predict(VALUES_IN, OVERFLOW_IN);
                e.due     = cyc + NC - 1;
                holdFrom  = cyc + NC;
                modelBusy = 1'b1;
                expQ.push_back(e);
            end
        end
    end

    // Monitor: compares each presented result with the scoreboard head and checks it stays stable.
    initial begin
        exp_t held;
        bit   presented;
        int   seenEpoch;
        presented = 1'b0;
        seenEpoch = 0;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            if (epoch != seenEpoch) begin
                seenEpoch = epoch;
                presented = 1'b0;
            end
            checkOutput("busy", int'(BUSY), int'(modelBusy));
            checkOutput("drop_count", int'(DROP_COUNT), drops);
            if (VALID_OUT) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_valid", int'(VALID_OUT), 0);
                end else if (!presented) begin
                    checkOutput("class", int'(CLASS_OUT), expQ[0].cls);
                    checkOutput("confidence", int'(CONFIDENCE_OUT), expQ[0].conf);
                    checkOutput("ambiguous", int'(AMBIGUOUS_OUT), expQ[0].amb);
                    checkOutput("overflow", int'(OVERFLOW_OUT), expQ[0].ovf);
                    checkOutput("latency", cyc, expQ[0].due);
                    held.cls  = int'(CLASS_OUT);
                    held.conf = int'(CONFIDENCE_OUT);
                    held.amb  = int'(AMBIGUOUS_OUT);
                    held.ovf  = int'(OVERFLOW_OUT);
                    presented = 1'b1;
                end else begin
                    checkOutput("stable_class", int'(CLASS_OUT), held.cls);
                    checkOutput("stable_conf", int'(CONFIDENCE_OUT), held.conf);
                    checkOutput("stable_amb", int'(AMBIGUOUS_OUT), held.amb);
                    checkOutput("stable_ovf", int'(OVERFLOW_OUT), held.ovf);
                end
                if (READY_IN && expQ.size() > 0) begin
                    void'(expQ.pop_front());
                    presented = 1'b0;
                end
            end else if (expQ.size() > 0 && cyc >= expQ[0].due) begin
                checkOutput("valid_late", int'(VALID_OUT), 1);
                void'(expQ.pop_front());
                presented = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST         = 1'b1;
        VALID_IN    = 1'b0;
        READY_IN    = 1'b0;
        OVERFLOW_IN = 1'b0;
        VALUES_IN   = '0;
        repeat (3) tick();
        RST = 1'b0;

        checkOutput("reset_class", int'(CLASS_OUT), 0);
        checkOutput("reset_conf", int'(CONFIDENCE_OUT), 0);
        checkOutput("reset_amb", int'(AMBIGUOUS_OUT), 0);
        checkOutput("reset_ovf", int'(OVERFLOW_OUT), 0);
        checkOutput("reset_valid", int'(VALID_OUT), 0);
        checkOutput("reset_busy", int'(BUSY), 0);
        checkOutput("reset_drops", int'(DROP_COUNT), 0);

        READY_IN = 1'b1;
        applyStimulus({8'hE0, 8'h20, 8'hE0}, 1'b0);
        waitIdle();
        applyStimulus({8'h10, 8'h10, 8'h00}, 1'b0);
        waitIdle();
        applyStimulus({8'h00, 8'h14, 8'h0D}, 1'b1);
        waitIdle();
        applyStimulus({8'h80, 8'h7F, 8'h80}, 1'b1);
        waitIdle();
        applyStimulus({8'hE0, 8'hF0, 8'hE0}, 1'b0);
        waitIdle();

        // Backpressure with two pulses lost during scan and hold.
        READY_IN = 1'b0;
        applyStimulus({8'h05, 8'h30, 8'h2F}, 1'b1);
        VALID_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
        repeat (2) tick();
        VALID_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
        repeat (6) tick();
        checkOutput("drops_two", int'(DROP_COUNT), 2);
        checkOutput("held_valid", int'(VALID_OUT), 1);
        READY_IN = 1'b1;
        tick();
        checkOutput("accept_valid_low", int'(VALID_OUT), 0);
        checkOutput("accept_busy_low", int'(BUSY), 0);

        // Saturating drop counter.
        READY_IN = 1'b0;
        applyStimulus({8'h01, 8'h02, 8'h03}, 1'b0);
        VALID_IN = 1'b1;
        repeat (300) tick();
        VALID_IN = 1'b0;
        checkOutput("drops_saturated", int'(DROP_COUNT), 255);
        READY_IN = 1'b1;
        waitIdle();

        // Reset one cycle after a vector is accepted.
        applyStimulus({8'h40, 8'h10, 8'h20}, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("midrst_busy", int'(BUSY), 0);
        checkOutput("midrst_valid", int'(VALID_OUT), 0);
        checkOutput("midrst_drops", int'(DROP_COUNT), 0);
        repeat (6) tick();
        applyStimulus({8'h40, 8'h10, 8'h20}, 1'b0);
        waitIdle();

        // Random traffic with random backpressure and pulses that may land while busy.
        for (int n = 0; n < 200; n++) begin
            READY_IN    = ($urandom_range(0, 3) != 0);
            VALID_IN    = ($urandom_range(0, 1) == 1);
            VALUES_IN   = randVals();
            OVERFLOW_IN = ($urandom_range(0, 1) == 1);
            tick();
        end
        VALID_IN = 1'b0;
        READY_IN = 1'b1;
        waitIdle();
        repeat (3) tick();
        checkOutput("pending_results", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
